rtc_bus_scheduler: RTL and testbench

Schedules all accesses to the RTC multiplexed-bus engine, which drives ADout/ad/wr/rd/cs. It arbitrates between PicoBlaze port commands (write_strobe/id_port/out_port) and an internal periodic refresh that reads seconds, minutes and hours into shadow registers for the display path. It sits between the PicoBlaze port decode and the bus-cycle engine, and is the only master of that engine.

---
 rtl/rtc_bus_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_scheduler.sv
// Sole master of the RTC bus-cycle engine: arbitrates PicoBlaze port commands
// against a periodic seconds/minutes/hours refresh into display shadows.
module rtc_bus_scheduler #(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned TIMEOUT        = 255,
    parameter logic [7:0]  ADDR_SEC       = 8'h21,
    parameter logic [7:0]  ADDR_MIN       = 8'h22,
    parameter logic [7:0]  ADDR_HOUR      = 8'h23
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       write_strobe,
    input  logic [7:0] id_port,
    input  logic [7:0] out_port,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_done,
    input  logic [7:0] bus_rdata,
    output logic [7:0] host_rdata,
    output logic       host_valid,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       overrun,
    output logic       timeout_err,
    output logic       busy
);

    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);
    localparam logic [7:0] ID_ADDR   = 8'h01;
    localparam logic [7:0] ID_WR     = 8'h02;
    localparam logic [7:0] ID_RD     = 8'h03;
    localparam logic [7:0] CLEAR_PAT = 8'hFF;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } bus_cmd_t;

    typedef enum logic [1:0] {IDLE, HOST, REF} state_t;

    state_t          state, state_nxt;
    bus_cmd_t        cmd, cmd_nxt;
    bus_cmd_t        slot, slot_nxt;
    logic            slot_full, slot_full_nxt;
    logic            req_nxt;
    logic [TW-1:0]   wait_cnt, wait_nxt;
    logic [7:0]      haddr, haddr_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [2:0][7:0] shadow, shadow_nxt;
    logic [RW-1:0]   ref_cnt, ref_cnt_nxt;
    logic            ref_pending, ref_pending_nxt;
    logic [7:0]      rdata_nxt;
    logic            valid_nxt;
    logic [7:0]      sec_nxt, min_nxt, hour_nxt;
    logic            overrun_nxt, terr_nxt, busy_nxt;
    logic            slot_release, seq_wrap, ref_fire, is_cmd;
    logic [7:0]      ref_addr;

    assign bus_we    = cmd.we;
    assign bus_addr  = cmd.addr;
    assign bus_wdata = cmd.wdata;

    // Next-state, slot bookkeeping and registered-output values.
    always_comb begin
        state_nxt     = state;
        cmd_nxt       = cmd;
        req_nxt       = bus_req;
        wait_nxt      = wait_cnt;
        slot_nxt      = slot;
        slot_full_nxt = slot_full;
        haddr_nxt     = haddr;
        idx_nxt       = idx;
        shadow_nxt    = shadow;
        rdata_nxt     = host_rdata;
        valid_nxt     = 1'b0;
        sec_nxt       = sec;
        min_nxt       = min;
        hour_nxt      = hour;
        overrun_nxt   = overrun;
        terr_nxt      = timeout_err;
        slot_release  = 1'b0;
        seq_wrap      = 1'b0;
        ref_fire      = (ref_cnt == '0);
        ref_cnt_nxt   = ref_fire ? REF_RELOAD : ref_cnt - RW'(1);
        is_cmd        = (id_port == ID_WR) || (id_port == ID_RD);

        case (idx)
            2'd0:    ref_addr = ADDR_SEC;
            2'd1:    ref_addr = ADDR_MIN;
            default: ref_addr = ADDR_HOUR;
        endcase

        case (state)
            IDLE: begin
                wait_nxt = '0;
                if (slot_full) begin
                    state_nxt = HOST;
                    req_nxt   = 1'b1;
                    cmd_nxt   = slot;
                end else if (ref_pending || (idx != 2'd0)) begin
                    state_nxt = REF;
                    req_nxt   = 1'b1;
                    cmd_nxt   = '{we: 1'b0, addr: ref_addr, wdata: 8'h00};
                end
            end
            HOST, REF: begin
                if (bus_done) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                    if (state == HOST) begin
                        slot_release = 1'b1;
                        if (!cmd.we) begin
                            rdata_nxt = bus_rdata;
                            valid_nxt = 1'b1;
                        end
                    end else begin
                        shadow_nxt[idx] = bus_rdata;
                        if (idx == 2'd2) begin
                            // hour comes straight from the bus: its shadow slot is written this same edge
                            sec_nxt  = shadow[0];
                            min_nxt  = shadow[1];
                            hour_nxt = bus_rdata;
                            idx_nxt  = 2'd0;
                            seq_wrap = 1'b1;
                        end else begin
                            idx_nxt = idx + 2'd1;
                        end
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    // abandoned refresh keeps idx so the same register is retried
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                    terr_nxt  = 1'b1;
                    if (state == HOST) begin
                        slot_release = 1'b1;
                    end
                end else begin
                    wait_nxt = wait_cnt + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase

        // Port decode; a slot freed this edge can accept a new command.
        if (slot_release) begin
            slot_full_nxt = 1'b0;
        end
        if (write_strobe) begin
            if (id_port == ID_ADDR) begin
                haddr_nxt = out_port;
            end else if ((id_port == ID_WR) && (out_port == CLEAR_PAT)) begin
                overrun_nxt = 1'b0;
            end else if (is_cmd) begin
                if (slot_full_nxt) begin
                    overrun_nxt = 1'b1;
                end else begin
                    slot_full_nxt = 1'b1;
                    slot_nxt      = '{we: (id_port == ID_WR), addr: haddr, wdata: out_port};
                end
            end
        end

        // A timer expiry coinciding with sequence completion starts a fresh sequence.
        ref_pending_nxt = ref_fire ? 1'b1 : (seq_wrap ? 1'b0 : ref_pending);
        busy_nxt        = (state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            cmd         <= '0;
            bus_req     <= 1'b0;
            wait_cnt    <= '0;
            slot        <= '0;
            slot_full   <= 1'b0;
            haddr       <= 8'h00;
            idx         <= 2'd0;
            shadow      <= '0;
            ref_cnt     <= REF_RELOAD;
            ref_pending <= 1'b0;
            host_rdata  <= 8'h00;
            host_valid  <= 1'b0;
            sec         <= 8'h00;
            min         <= 8'h00;
            hour        <= 8'h00;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd         <= cmd_nxt;
            bus_req     <= req_nxt;
            wait_cnt    <= wait_nxt;
            slot        <= slot_nxt;
            slot_full   <= slot_full_nxt;
            haddr       <= haddr_nxt;
            idx         <= idx_nxt;
            shadow      <= shadow_nxt;
            ref_cnt     <= ref_cnt_nxt;
            ref_pending <= ref_pending_nxt;
            host_rdata  <= rdata_nxt;
            host_valid  <= valid_nxt;
            sec         <= sec_nxt;
            min         <= min_nxt;
            hour        <= hour_nxt;
            overrun     <= overrun_nxt;
            timeout_err <= terr_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler: directed scenarios plus random traffic, every
// cycle compared against a transaction-level reference of the scheduling rules.
module tb_rtc_bus_scheduler;

    localparam int REF = 50;
    localparam int TO  = 10;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       write_strobe = 1'b0;
    logic [7:0] id_port = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       bus_done = 1'b0;
    logic [7:0] bus_rdata = 8'h00;
    logic       bus_req, bus_we, host_valid, overrun, timeout_err, busy;
    logic [7:0] bus_addr, bus_wdata, host_rdata, sec, min, hour;

    rtc_bus_scheduler #(.REFRESH_CYCLES(REF), .TIMEOUT(TO)) dut (
        .CLK(CLK), .reset(reset), .write_strobe(write_strobe), .id_port(id_port),
        .out_port(out_port), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_done(bus_done), .bus_rdata(bus_rdata),
        .host_rdata(host_rdata), .host_valid(host_valid), .sec(sec), .min(min),
        .hour(hour), .overrun(overrun), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference: what the scheduler owes and what the bus is doing right now.
    int         m_timer, m_seq, m_elapsed;
    bit         m_owed, m_slot, m_slot_we, m_req, m_txn_host, m_we;
    bit         m_valid, m_over, m_terr;
    logic [7:0] m_slot_addr, m_slot_data, m_haddr, m_addr, m_wdata;
    logic [7:0] m_rdata, m_sec, m_min, m_hour;
    logic [7:0] m_shadow [3];

    // Bus engine behaviour and observed transaction log.
    logic [7:0] mem [256];
    logic [8:0] txlog [$];
    int  eng_fixed_lat = 0;
    int  eng_cnt = 0;
    bit  eng_silent = 0, eng_random = 0, eng_mute = 0, eng_prev_req = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit freed, wrapped, fire;
        if (reset) begin
            m_timer = REF - 1; m_seq = 0; m_elapsed = 0;
            m_owed = 0; m_slot = 0; m_slot_we = 0; m_req = 0; m_txn_host = 0; m_we = 0;
            m_valid = 0; m_over = 0; m_terr = 0;
            m_slot_addr = 0; m_slot_data = 0; m_haddr = 0; m_addr = 0; m_wdata = 0;
            m_rdata = 0; m_sec = 0; m_min = 0; m_hour = 0;
            for (int i = 0; i < 3; i++) m_shadow[i] = 0;
            return;
        end
        freed = 0; wrapped = 0; m_valid = 0;
        fire = (m_timer == 0);
        m_timer = fire ? REF - 1 : m_timer - 1;
        if (m_req) begin
            if (bus_done) begin
                m_req = 0;
                if (m_txn_host) begin
                    freed = 1;
                    if (!m_we) begin m_rdata = bus_rdata; m_valid = 1; end
                end else begin
                    m_shadow[m_seq] = bus_rdata;
                    if (m_seq == 2) begin
                        m_sec = m_shadow[0]; m_min = m_shadow[1]; m_hour = m_shadow[2];
                        m_seq = 0; wrapped = 1;
                    end else m_seq++;
                end
            end else if (m_elapsed == TO - 1) begin
                m_req = 0; m_terr = 1;
                if (m_txn_host) freed = 1;
            end else m_elapsed++;
        end else if (m_slot) begin
            m_req = 1; m_txn_host = 1; m_elapsed = 0;
            m_we = m_slot_we; m_addr = m_slot_addr; m_wdata = m_slot_data;
        end else if (m_owed || m_seq != 0) begin
            m_req = 1; m_txn_host = 0; m_elapsed = 0;
            m_we = 0; m_addr = 8'h21 + 8'(m_seq);
        end
        if (freed) m_slot = 0;
        if (write_strobe) begin
            if (id_port == 8'h01) m_haddr = out_port;
            else if (id_port == 8'h02 && out_port == 8'hFF) m_over = 0;
            else if (id_port == 8'h02 || id_port == 8'h03) begin
                if (m_slot) m_over = 1;
                else begin
                    m_slot = 1; m_slot_we = (id_port == 8'h02);
                    m_slot_addr = m_haddr; m_slot_data = out_port;
                end
            end
        end
        if (fire) m_owed = 1;
        else if (wrapped) m_owed = 0;
    endtask

    task automatic compare_all();
        check("bus_req", bus_req, m_req);
        check("busy", busy, m_req);
        check("host_valid", host_valid, m_valid);
        check("host_rdata", host_rdata, m_rdata);
        check("sec", sec, m_sec);
        check("min", min, m_min);
        check("hour", hour, m_hour);
        check("overrun", overrun, m_over);
        check("timeout_err", timeout_err, m_terr);
        if (m_req) begin
            check("bus_we", bus_we, m_we);
            check("bus_addr", bus_addr, m_addr);
            if (m_we) check("bus_wdata", bus_wdata, m_wdata);
        end
    endtask

    task automatic engine();
        bus_done = 1'b0;
        bus_rdata = 8'($urandom);
        if (bus_req === 1'b1) begin
            if (!eng_prev_req) begin
                txlog.push_back({bus_we, bus_addr});
                eng_cnt = (eng_fixed_lat >= 0) ? eng_fixed_lat : int'($urandom_range(0, 6));
                eng_mute = eng_silent || (eng_random && $urandom_range(0, 15) == 0);
            end else if (eng_cnt > 0) eng_cnt--;
            if (eng_cnt == 0 && !eng_mute) begin
                bus_done = 1'b1;
                if (bus_we) mem[bus_addr] = bus_wdata;
                else bus_rdata = mem[bus_addr];
            end
        end
        eng_prev_req = (bus_req === 1'b1);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
        engine();
    endtask

    task automatic strobe(input logic [7:0] id, input logic [7:0] data);
        write_strobe = 1'b1; id_port = id; out_port = data;
        tick();
        write_strobe = 1'b0; id_port = 8'h00; out_port = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [8:0] txn(input int i);
        return (i < txlog.size()) ? txlog[i] : 9'h1FF;
    endfunction

    task automatic check_all_zero(input string tag);
        logic [7:0] ored;
        ored = host_rdata | sec | min | hour;
        check({tag, "_regs"}, ored, 8'h00);
        check({tag, "_flags"}, {bus_req, host_valid, overrun, timeout_err, busy}, 5'b0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Host write: bus_req two cycles after the command strobe, 5-cycle engine latency.
        do_reset();
        check_all_zero("reset");
        eng_fixed_lat = 5;
        strobe(8'h01, 8'h21);
        strobe(8'h02, 8'h45);
        check("t1_req_n1", bus_req, 1'b0);
        tick();
        check("t1_req_n2", bus_req, 1'b1);
        check("t1_we", bus_we, 1'b1);
        check("t1_addr", bus_addr, 8'h21);
        check("t1_wdata", bus_wdata, 8'h45);
        n = 1;
        while (bus_req && n < 20) begin tick(); if (bus_req) n++; end
        check("t1_req_cycles", n, 6);
        check("t1_mem", mem[8'h21], 8'h45);

        // Host read: one-cycle host_valid with the returned data.
        mem[8'h22] = 8'h30;
        strobe(8'h01, 8'h22);
        strobe(8'h03, 8'h00);
        n = 0;
        while (!host_valid && n < 30) begin tick(); n++; end
        check("t2_valid_seen", host_valid, 1'b1);
        check("t2_rdata", host_rdata, 8'h30);
        tick();
        check("t2_valid_pulse", host_valid, 1'b0);

        // Refresh sequence: three reads in order, shadows published together.
        do_reset();
        mem[8'h21] = 8'h12; mem[8'h22] = 8'h34; mem[8'h23] = 8'h56;
        eng_fixed_lat = 2;
        txlog.delete();
        n = 0;
        while ((sec | min | hour) == 8'h00 && n < 200) begin tick(); n++; end
        check("t3_sec", sec, 8'h12);
        check("t3_min", min, 8'h34);
        check("t3_hour", hour, 8'h56);
        check("t3_tx0", txn(0), 9'h021);
        check("t3_tx1", txn(1), 9'h022);
        check("t3_tx2", txn(2), 9'h023);

        // Host write lands between the MIN and HOUR refresh reads.
        do_reset();
        eng_fixed_lat = 4;
        txlog.delete();
        strobe(8'h01, 8'h40);
        n = 0;
        while (!(bus_req && bus_addr == 8'h22) && n < 100) begin tick(); n++; end
        strobe(8'h02, 8'h77);
        n = 0;
        while ((sec | min | hour) == 8'h00 && n < 100) begin tick(); n++; end
        check("t4_tx0", txn(0), 9'h021);
        check("t4_tx1", txn(1), 9'h022);
        check("t4_tx2", txn(2), 9'h140);
        check("t4_tx3", txn(3), 9'h023);
        check("t4_shadow", {sec, min, hour}, 24'h123456);
        check("t4_mem", mem[8'h40], 8'h77);

        // Second command while the first is in flight is dropped; clear pattern is not queued.
        do_reset();
        eng_fixed_lat = 8;
        strobe(8'h01, 8'h30);
        strobe(8'h02, 8'h11);
        strobe(8'h02, 8'h22);
        check("t5_overrun_set", overrun, 1'b1);
        n = 0;
        while (bus_req && n < 30) begin tick(); n++; end
        tick(); tick();
        txlog.delete();
        strobe(8'h02, 8'hFF);
        check("t5_overrun_clr", overrun, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_txn", txlog.size(), 0);
        check("t5_mem", mem[8'h30], 8'h11);

        // Silent engine: timeout after TO cycles, host command discarded, refresh retried.
        do_reset();
        eng_silent = 1;
        strobe(8'h01, 8'h50);
        strobe(8'h02, 8'h5A);
        tick();
        n = 1;
        while (bus_req && n < 30) begin tick(); if (bus_req) n++; end
        check("t6_req_cycles", n, TO);
        check("t6_terr", timeout_err, 1'b1);
        tick(); tick(); tick();
        check("t6_no_retry", bus_req, 1'b0);
        txlog.delete();
        n = 0;
        while (txlog.size() < 2 && n < 200) begin tick(); n++; end
        check("t6_retry0", txn(0), 9'h021);
        check("t6_retry1", txn(1), 9'h021);
        tick(); tick(); tick();
        reset = 1'b1;
        bus_done = 1'b1;
        tick();
        check_all_zero("t6_reset");
        reset = 1'b0;
        eng_silent = 0;

        // Random traffic against the reference.
        do_reset();
        eng_fixed_lat = -1;
        eng_random = 1;
        for (int c = 0; c < 3000; c++) begin
            int r;
            reset = ($urandom_range(0, 399) == 0);
            write_strobe = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 9));
            id_port = (r < 3) ? 8'h01 : (r < 6) ? 8'h02 : (r < 8) ? 8'h03 :
                      (r == 8) ? 8'h04 : 8'($urandom);
            out_port = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            tick();
        end
        reset = 1'b0; write_strobe = 1'b0; id_port = 8'h00; out_port = 8'h00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
